bcd_decade_ctrl: RTL and testbench
==================================

// Module: bcd_decade_ctrl
// PURPOSE
//  Run controller for a multi-decade BCD counter. Divides clk into count ticks,
//  sequences per-decade enables along the carry chain, and holds the decade registers.
//  Handles start/stop/clear commands and stops on a BCD limit or on overflow.
//  Sits between the command/timer logic and the BCD digit display/readout path.
// PARAMETERS
//  DECADES   4   number of BCD digits (>=1); digit 0 is least significant
//  PRESCALE  10  clk cycles per count tick (>=1; 1 = tick every RUN cycle)
//  ROLLOVER  0   1: all-9s wraps to 0 and keeps running; 0: holds at all-9s, goes DONE
// PORTS
//  clk       in   1          clock, all logic on rising edge
//  rst       in   1          synchronous reset, active-high
//  start     in   1          begin/resume counting (level, sampled each cycle)
//  stop      in   1          pause counting (level)
//  clear     in   1          zero count and prescaler, return to IDLE
//  limit     in   4*DECADES  BCD terminal value; a nibble >9 never matches
//  count     out  4*DECADES  BCD count, registered
//  digit_en  out  DECADES    per-decade increment enable, combinational, valid in tick cycle
//  running   out  1          1 in RUN state
//  done      out  1          1 in DONE state (level)
//  ovf       out  1          one-cycle pulse on all-9s tick
// BEHAVIOUR
//  Reset: state IDLE, count 0, prescaler 0, running 0, done 0, ovf 0, digit_en 0.
//  Priority each cycle: rst > clear > stop > start.
//  FSM: IDLE -start-> RUN (prescaler zeroed); RUN -stop-> HOLD; HOLD -start-> RUN
//   (prescaler kept); RUN -limit hit or (overflow & ROLLOVER=0)-> DONE;
//   DONE ignores start/stop, leaves only on clear/rst. clear in any state -> IDLE, count 0.
//  start & stop together: stop wins (RUN->HOLD, IDLE/HOLD stay).
//  Prescaler: counts 0..PRESCALE-1 in RUN only; tick = RUN & presc==PRESCALE-1;
//   presc wraps to 0 on tick. Frozen in IDLE/HOLD/DONE.
//  digit_en[0] = tick; digit_en[i] = tick & (count digits 0..i-1 all == 9).
//  Digit with enable: 9->0, else +1. count updates on the edge ending the tick cycle.
//   First tick from IDLE occurs PRESCALE cycles after the start edge.
//  Limit: on a tick edge where next count == limit, state -> DONE on that same edge
//   (done=1 with count==limit). limit==0 is never reached from counting except by wrap.
//  Overflow (tick with all digits 9): ovf=1 for the cycle after the edge.
//   ROLLOVER=1: count -> 0, stays RUN. ROLLOVER=0: count held at all-9s, state -> DONE.
//   If wrapped value equals limit (limit=0, ROLLOVER=1), DONE takes effect; ovf still pulses.
//  stop during tick cycle: tick still applied (count updates), state -> HOLD.
//  clear during tick cycle: clear wins, count 0, no ovf, no DONE.
//  rst mid-run: all state as reset next cycle; no partial carry.
//  No invalid BCD ever produced internally; count only changes via tick/clear/rst.
// STRUCTURE
//  Package bcd_ctrl_pkg: state enum {S_IDLE,S_RUN,S_HOLD,S_DONE}, BCD_MAX=4'd9,
//   BCD_ZERO=4'd0, prescaler width function clog2.
//  Sub-module bcd_digit: 4-bit BCD register, inputs clk,rst,clr,en; outputs q, is9.
//   Instantiated DECADES times by generate; carry chain built from is9 in controller.
//  Controller: FSM, prescaler, enable chain, limit compare on next-count, ovf register.
// TESTING
//  Reset: rst=1 3 cycles -> count=0, running=0, done=0, ovf=0, digit_en=0.
//  DECADES=2,PRESCALE=1,limit=8'h99,start held -> count 00,01..09,10 in consecutive
//   cycles; 09->10 cycle has digit_en=2'b11.
//  PRESCALE=3: start, stop at count=05 mid-prescale, start 4 cycles later -> next tick
//   after remaining prescale cycles only; count 06; prescaler not zeroed.
//  limit=8'h25,PRESCALE=1 -> count stops at 25, done=1, running=0; start ignored;
//   clear -> IDLE, count 00.
//  ROLLOVER=1,limit=8'hAA -> 99->00, one-cycle ovf, running stays 1.
//   ROLLOVER=0 -> holds 99, ovf pulse, done=1.
//  Simultaneous: start&stop in IDLE -> stays IDLE; clear on overflow tick -> count 00, ovf 0.
//   rst during RUN at count 47 -> 00/IDLE next cycle.

Source files
------------

// File: rtl/bcd_ctrl_pkg.sv
// Shared types and constants for the BCD decade run controller.
package bcd_ctrl_pkg;

  // Controller run states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  // Bits needed to hold 0..value-1; never less than one so a prescale of 1
  // still yields a legal (constant zero) register.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD decade register: increments 0..9 and wraps, with a carry-out flag.
module bcd_digit
  import bcd_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] q,
  output logic       is9
);

  logic [3:0] q_reg;

  // Digit register; anything at or above 9 folds to zero so no invalid code survives
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q_reg <= BCD_ZERO;
    end else if (en) begin
      q_reg <= (q_reg >= BCD_MAX) ? BCD_ZERO : q_reg + 4'd1;
    end
  end

  assign q   = q_reg;
  assign is9 = (q_reg == BCD_MAX);

endmodule

// File: rtl/bcd_decade_ctrl.sv
// Run controller for a multi-decade BCD counter: prescaler, carry-chain enables,
// limit/overflow detection and the IDLE/RUN/HOLD/DONE sequencing.
module bcd_decade_ctrl
  import bcd_ctrl_pkg::*;
#(
  parameter int DECADES  = 4,
  parameter int PRESCALE = 10,
  parameter int ROLLOVER = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   clear,
  input  logic [4*DECADES-1:0]   limit,
  output logic [4*DECADES-1:0]   count,
  output logic [DECADES-1:0]     digit_en,
  output logic                   running,
  output logic                   done,
  output logic                   ovf
);

  localparam int             PW         = clog2(PRESCALE);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESCALE - 1);

  state_t              state_reg, state_next;
  logic [PW-1:0]       presc_reg, presc_next;
  logic                ovf_reg;

  logic [DECADES:0]    carry;
  logic [DECADES-1:0]  is9;
  logic [DECADES-1:0]  inc_en;
  logic [4*DECADES-1:0] count_next;
  logic                tick;
  logic                all9;
  logic                hold_top;
  logic                limit_hit;

  assign tick     = (state_reg == S_RUN) && (presc_reg == PRESC_LAST);
  assign carry[0] = 1'b1;
  assign all9     = carry[DECADES];
  // Without rollover the all-9s tick must leave the count parked at all-9s
  assign hold_top = all9 && (ROLLOVER == 0);

  genvar gi;
  generate
    for (gi = 0; gi < DECADES; gi++) begin : g_decade
      assign carry[gi+1]  = carry[gi] & is9[gi];
      assign digit_en[gi] = tick & carry[gi];
      assign inc_en[gi]   = digit_en[gi] & ~hold_top;

      bcd_digit u_digit (
        .clk (clk),
        .rst (rst),
        .clr (clear),
        .en  (inc_en[gi]),
        .q   (count[4*gi +: 4]),
        .is9 (is9[gi])
      );

      // Value this decade will hold after the edge, used for the limit compare
      assign count_next[4*gi +: 4] = inc_en[gi]
                                   ? (is9[gi] ? BCD_ZERO : count[4*gi +: 4] + 4'd1)
                                   : count[4*gi +: 4];
    end
  endgenerate

  // count_next is always valid BCD, so a limit nibble above 9 can never match
  assign limit_hit = tick && (count_next == limit);

  // Next-state logic: clear overrides everything, stop beats start, DONE is sticky
  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: if (start && !stop) state_next = S_RUN;
        S_RUN: begin
          if (limit_hit || (tick && hold_top)) begin
            state_next = S_DONE;
          end else if (stop) begin
            state_next = S_HOLD;
          end
        end
        S_HOLD: if (start && !stop) state_next = S_RUN;
        S_DONE: state_next = S_DONE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Prescaler advances only in RUN; IDLE keeps it zero so RUN entry starts fresh
  always_comb begin
    presc_next = presc_reg;
    if (clear || (state_reg == S_IDLE)) begin
      presc_next = '0;
    end else if (state_reg == S_RUN) begin
      presc_next = tick ? '0 : presc_reg + PW'(1);
    end
  end

  // State, prescaler and overflow pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      presc_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      presc_reg <= presc_next;
      ovf_reg   <= tick && all9 && !clear;
    end
  end

  assign running = (state_reg == S_RUN);
  assign done    = (state_reg == S_DONE);
  assign ovf     = ovf_reg;

endmodule

// File: tb/tb_bcd_decade_ctrl.sv
// Self-checking bench: four controller configurations share one stimulus stream,
// an integer-arithmetic model predicts every output each cycle, and literal
// checks pin the directed scenarios.
module tb_bcd_decade_ctrl;

  logic clk;
  logic rst, start, stop, clear;
  logic [7:0]  lim8;
  logic [15:0] lim16;

  logic [7:0]  c0, c1, c2;
  logic [15:0] c3;
  logic [1:0]  de0, de1, de2;
  logic [3:0]  de3;
  logic        run0, run1, run2, run3;
  logic        dn0, dn1, dn2, dn3;
  logic        ov0, ov1, ov2, ov3;

  logic [15:0] cnt_a  [4];
  logic [3:0]  den_a  [4];
  logic        run_a  [4];
  logic        done_a [4];
  logic        ovf_a  [4];

  int  n_chk;
  int  n_fail;
  bit  chk_on;

  assign lim16 = {8'hFF, lim8};

  bcd_decade_ctrl #(.DECADES(2), .PRESCALE(1), .ROLLOVER(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .limit(lim8),
    .count(c0), .digit_en(de0), .running(run0), .done(dn0), .ovf(ov0));
  bcd_decade_ctrl #(.DECADES(2), .PRESCALE(3), .ROLLOVER(0)) u1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .limit(lim8),
    .count(c1), .digit_en(de1), .running(run1), .done(dn1), .ovf(ov1));
  bcd_decade_ctrl #(.DECADES(2), .PRESCALE(1), .ROLLOVER(1)) u2 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .limit(lim8),
    .count(c2), .digit_en(de2), .running(run2), .done(dn2), .ovf(ov2));
  bcd_decade_ctrl u3 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .limit(lim16),
    .count(c3), .digit_en(de3), .running(run3), .done(dn3), .ovf(ov3));

  assign cnt_a[0] = {8'h00, c0};  assign den_a[0] = {2'b00, de0};
  assign cnt_a[1] = {8'h00, c1};  assign den_a[1] = {2'b00, de1};
  assign cnt_a[2] = {8'h00, c2};  assign den_a[2] = {2'b00, de2};
  assign cnt_a[3] = c3;           assign den_a[3] = de3;
  assign run_a[0] = run0;  assign run_a[1] = run1;  assign run_a[2] = run2;  assign run_a[3] = run3;
  assign done_a[0] = dn0;  assign done_a[1] = dn1;  assign done_a[2] = dn2;  assign done_a[3] = dn3;
  assign ovf_a[0] = ov0;   assign ovf_a[1] = ov1;   assign ovf_a[2] = ov2;   assign ovf_a[3] = ov3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_DONE = 3;

  typedef struct packed {
    int mode;
    int n;      // count as a plain decimal integer
    int presc;
    bit ovf;
  } mst_t;

  mst_t ms [4];

  function automatic int dk(input int k);
    return (k == 3) ? 4 : 2;
  endfunction
  function automatic int pk(input int k);
    case (k)
      1:       return 3;
      3:       return 10;
      default: return 1;
    endcase
  endfunction
  function automatic int rk(input int k);
    return (k == 2) ? 1 : 0;
  endfunction

  function automatic int pow10(input int d);
    int r;
    r = 1;
    for (int i = 0; i < d; i++) r = r * 10;
    return r;
  endfunction

  function automatic int bcd2int(input logic [15:0] v, input int d);
    int r;
    logic [3:0] nib;
    r = 0;
    for (int i = d - 1; i >= 0; i--) begin
      nib = v[4*i +: 4];
      if (nib > 4'd9) return -1;
      r = r * 10 + int'(nib);
    end
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int n, input int d);
    logic [15:0] r;
    int v;
    r = '0;
    v = n;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic bit mtick(input mst_t s, input int p);
    return (s.mode == M_RUN) && (s.presc == p - 1);
  endfunction

  // Enables: tick sets the lowest digit plus one more per trailing 9
  function automatic logic [3:0] exp_en(input int n, input int d, input bit t);
    int nines;
    int v;
    if (!t) return 4'h0;
    nines = 0;
    v = n;
    while (nines < d && (v % 10) == 9) begin
      nines++;
      v = v / 10;
    end
    if (nines > d - 1) nines = d - 1;
    return 4'((1 << (nines + 1)) - 1);
  endfunction

  function automatic mst_t step(input mst_t s, input int d, input int p, input int r,
                                input bit i_rst, input bit i_clr, input bit i_start,
                                input bit i_stop, input int lim);
    mst_t ns;
    bit   t;
    int   maxv;
    ns     = s;
    ns.ovf = 1'b0;
    maxv   = pow10(d) - 1;
    if (i_rst || i_clr) begin
      ns.mode = M_IDLE; ns.n = 0; ns.presc = 0;
      return ns;
    end
    t = mtick(s, p);
    case (s.mode)
      M_IDLE: if (i_start && !i_stop) begin ns.mode = M_RUN; ns.presc = 0; end
      M_HOLD: if (i_start && !i_stop) ns.mode = M_RUN;
      M_RUN: begin
        ns.presc = t ? 0 : s.presc + 1;
        if (i_stop) ns.mode = M_HOLD;
      end
      default: ;
    endcase
    if (t) begin
      if (s.n == maxv) begin
        ns.ovf = 1'b1;
        if (r != 0) ns.n = 0;
        else begin ns.n = maxv; ns.mode = M_DONE; end
      end else begin
        ns.n = s.n + 1;
      end
      if (ns.n == lim) ns.mode = M_DONE;
    end
    return ns;
  endfunction

  task automatic check(input string name, input int k, input logic [15:0] act,
                       input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, k, $time, act, exp);
    end
  endtask

  // Model advances on the same edge the DUTs sample their inputs
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      ms[k] <= step(ms[k], dk(k), pk(k), rk(k), rst, clear, start, stop,
                    bcd2int((k == 3) ? lim16 : {8'h00, lim8}, dk(k)));
    end
  end

  // Every-cycle comparison of all outputs of all four instances
  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 4; k++) begin
        check("count",    k, cnt_a[k], int2bcd(ms[k].n, dk(k)));
        check("digit_en", k, {12'h000, den_a[k]},
              {12'h000, exp_en(ms[k].n, dk(k), mtick(ms[k], pk(k)))});
        check("running",  k, {15'h0, run_a[k]},  {15'h0, ms[k].mode == M_RUN});
        check("done",     k, {15'h0, done_a[k]}, {15'h0, ms[k].mode == M_DONE});
        check("ovf",      k, {15'h0, ovf_a[k]},  {15'h0, ms[k].ovf});
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    n_chk = 0; n_fail = 0; chk_on = 1'b0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; lim8 = 8'h99;

    // Reset held three cycles
    @(negedge clk);
    chk_on = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_count", 0, cnt_a[0], 16'h0000);
    check("rst_count", 3, cnt_a[3], 16'h0000);
    check("rst_en",    3, {12'h0, den_a[3]}, 16'h0000);
    check("rst_flags", 0, {13'h0, run_a[0], done_a[0], ovf_a[0]}, 16'h0000);

    // Prescale 1: one count per cycle, carry into decade 1 at 09
    rst = 1'b0; start = 1'b1;
    @(negedge clk);
    check("run_first",  0, {15'h0, run_a[0]}, 16'h0001);
    check("cnt_first",  0, cnt_a[0], 16'h0000);
    repeat (9) @(negedge clk);
    check("cnt_09",     0, cnt_a[0], 16'h0009);
    check("en_carry",   0, {12'h0, den_a[0]}, 16'h0003);
    @(negedge clk);
    check("cnt_10",     0, cnt_a[0], 16'h0010);

    start = 1'b0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_cnt",    0, cnt_a[0], 16'h0000);

    // Prescale 3: stop mid-prescale at 05, resume keeps prescaler phase
    start = 1'b1;
    repeat (17) @(negedge clk);
    check("p3_cnt05",   1, cnt_a[1], 16'h0005);
    start = 1'b0; stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("p3_hold",    1, {15'h0, run_a[1]}, 16'h0000);
    repeat (3) @(negedge clk);
    check("p3_frozen",  1, cnt_a[1], 16'h0005);
    start = 1'b1;
    @(negedge clk);
    check("p3_resume",  1, cnt_a[1], 16'h0005);
    @(negedge clk);
    check("p3_cnt06",   1, cnt_a[1], 16'h0006);

    // Limit 25
    start = 1'b0; clear = 1'b1; lim8 = 8'h25;
    @(negedge clk);
    clear = 1'b0; start = 1'b1;
    repeat (30) @(negedge clk);
    check("lim_cnt",    0, cnt_a[0], 16'h0025);
    check("lim_done",   0, {14'h0, done_a[0], run_a[0]}, 16'h0002);
    repeat (3) @(negedge clk);
    check("lim_ignore", 0, cnt_a[0], 16'h0025);
    start = 1'b0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("lim_clr",    0, {14'h0, done_a[0], run_a[0]}, 16'h0000);
    check("lim_clrcnt", 0, cnt_a[0], 16'h0000);

    // Overflow: rollover instance wraps, non-rollover instance parks at 99
    lim8 = 8'hAA; start = 1'b1;
    repeat (100) @(negedge clk);
    check("ov_cnt99",   2, cnt_a[2], 16'h0099);
    check("ov_en",      2, {12'h0, den_a[2]}, 16'h0003);
    @(negedge clk);
    check("ov_wrap",    2, cnt_a[2], 16'h0000);
    check("ov_pulse",   2, {14'h0, ovf_a[2], run_a[2]}, 16'h0003);
    check("ov_park",    0, cnt_a[0], 16'h0099);
    check("ov_done",    0, {14'h0, ovf_a[0], done_a[0]}, 16'h0003);
    @(negedge clk);
    check("ov_end",     2, {15'h0, ovf_a[2]}, 16'h0000);
    check("ov_next",    2, cnt_a[2], 16'h0001);

    // start & stop together in IDLE
    start = 1'b0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; start = 1'b1; stop = 1'b1;
    repeat (3) @(negedge clk);
    check("ss_idle",    0, {15'h0, run_a[0]}, 16'h0000);
    stop = 1'b0;

    // clear on the overflow tick
    repeat (100) @(negedge clk);
    check("co_cnt99",   0, cnt_a[0], 16'h0099);
    start = 1'b0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("co_cnt",     0, cnt_a[0], 16'h0000);
    check("co_flags",   0, {14'h0, ovf_a[0], done_a[0]}, 16'h0000);
    check("co_ovf2",    2, {15'h0, ovf_a[2]}, 16'h0000);

    // Reset at count 47
    start = 1'b1;
    repeat (48) @(negedge clk);
    check("rr_cnt47",   0, cnt_a[0], 16'h0047);
    rst = 1'b1;
    @(negedge clk);
    check("rr_cnt",     0, cnt_a[0], 16'h0000);
    check("rr_run",     0, {15'h0, run_a[0]}, 16'h0000);
    rst = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
